if_stage_unit: RTL and testbench
================================

Name: if_stage_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage ARM core.
- Owns the PC, drives the instruction-memory address, and registers the fetched instruction and PC+4 into ID.
- Consumes the hazard unit's stall output as `freeze` and the EXE stage's branch resolution as `branch_taken` / `branch_address`.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- ADDR_W, 32, width of PC, branch address and memory address.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- freeze  input  1  stall request from the hazard detection unit; holds PC and IF/ID.
- branch_taken  input  1  branch resolved taken in EXE; redirects the PC and flushes IF/ID.
- branch_address  input  ADDR_W  branch target.
- imem_addr  output  ADDR_W  instruction-memory address (combinational, equals PC).
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- if_id_pc  output  ADDR_W  registered PC+4 of the instruction in ID.
- if_id_instr  output  32  registered instruction word.
- if_id_valid  output  1  1 = if_id_instr is a real fetched instruction; 0 = bubble.
- stall_count  output  CNT_W  number of freeze cycles since reset.
- flush_count  output  CNT_W  number of branch flushes since reset.

Behaviour:
- Reset (rst=0, asynchronous, takes effect mid-cycle):
  - pc = RESET_PC.
  - if_id_pc = 0, if_id_instr = 0, if_id_valid = 0.
  - stall_count = 0, flush_count = 0.
- Reset release: the first rising edge with rst=1 performs a normal update.
- imem_addr = pc, combinational, with no added latency. Memory is treated as zero-wait.
- Per rising edge, priority high to low:
  - branch_taken=1:
    - pc <= {branch_address[ADDR_W-1:2], 2'b00}; the low two bits are forced to zero.
    - IF/ID flushed: if_id_pc <= 0, if_id_instr <= 0, if_id_valid <= 0.
    - flush_count increments; stall_count does not, even if freeze=1.
    - Branch wins over freeze on both the PC and IF/ID.
  - freeze=1 (branch_taken=0):
    - pc, if_id_pc, if_id_instr and if_id_valid all hold.
    - stall_count increments.
  - Otherwise:
    - pc <= pc + 4.
    - if_id_pc <= pc + 4.
    - if_id_instr <= imem_data.
    - if_id_valid <= 1.
- Arithmetic: pc + 4 is computed modulo 2^ADDR_W. The wrap from all-ones-minus-3 to 0 is legal and silent.
- Counters saturate at 2^CNT_W-1; no wrap.
- Fetch-to-ID latency: one cycle. An instruction at address A appears in if_id_instr, with if_id_pc = A+4, one edge after imem_addr = A with freeze=0 and branch_taken=0.
- A bubble (valid=0) persists while freeze=1 follows a flush. The next un-frozen edge loads the instruction at the branch target.
- No X propagation: imem_data is only sampled on advance edges.
- Inputs are assumed synchronous to clk. No internal handshake beyond freeze.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: assert rst=0 mid-cycle, memory holds word i = 0x1000+i, release reset.
  - Required: outputs zero immediately. After edges 1, 2 and 3, if_id_pc = 4, 8, 12, if_id_instr = 0x1000, 0x1001, 0x1002, and valid=1.
- Freeze:
  - Stimulus: freeze=1 for 2 cycles at pc=8.
  - Required: imem_addr stays 8, IF/ID unchanged, stall_count = 2. On the next edge if_id_pc = 12.
- Branch flush:
  - Stimulus: branch_taken=1 with branch_address = 0x43 at pc=0x10.
  - Required: pc = 0x40, if_id_valid = 0, if_id_instr = 0, flush_count = 1. On the next edge if_id_pc = 0x44.
- Simultaneous branch and freeze:
  - Stimulus: both high for one edge, then freeze=1 alone for one edge.
  - Required: pc = target, IF/ID is a bubble, flush_count +1, stall_count +0. The bubble holds on the frozen edge, stall_count +1.
- PC wrap:
  - Stimulus: RESET_PC = 0xFFFF_FFFC with ADDR_W = 32, one advance edge.
  - Required: pc = 0, if_id_pc = 0.
- Counter saturation:
  - Stimulus: CNT_W = 4, freeze held for 20 cycles.
  - Required: stall_count stops at 15.
- Async reset during freeze:
  - Stimulus: assert rst=0 while freeze=1.
  - Required: all outputs reset immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_unit
// Brief    : Instruction fetch stage with IF/ID pipeline register and
//            saturating stall/flush event counters.
// Revision : 1.0
// ============================================================================
module if_stage_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_address,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic              if_id_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_target;
    logic              unused_addr_lsbs;

    // Targets are always word-aligned; the two low address bits are ignored.
    assign pc_plus4         = pc + ADDR_W'(4);
    assign branch_target    = {branch_address[ADDR_W-1:2], 2'b00};
    assign unused_addr_lsbs = ^branch_address[1:0];
    assign imem_addr        = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            pc          <= branch_target;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else if (!freeze) begin
            pc          <= pc_plus4;
            if_id_pc    <= pc_plus4;
            if_id_instr <= imem_data;
            if_id_valid <= 1'b1;
        end
    end

    // A branch edge counts only as a flush, never as a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (branch_taken) begin
                if (flush_count != '1) flush_count <= flush_count + 1'b1;
            end else if (freeze) begin
                if (stall_count != '1) stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage_unit.sv
`default_nettype none
// Testbench for if_stage_unit: directed vector table plus hand-written
// sequences for async reset, PC wrap and counter saturation.
module tb_if_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, branch_taken;
    logic [31:0] branch_address;
    logic [31:0] imem_addr, imem_data, if_id_pc, if_id_instr;
    logic        if_id_valid;
    logic [15:0] stall_count, flush_count;

    logic        freeze2;
    logic [31:0] imem_addr2, if_id_pc2, if_id_instr2;
    logic        if_id_valid2;
    logic [3:0]  stall_count2, flush_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory: word i holds 0x1000 + i.
    assign imem_data = 32'h1000 + (imem_addr >> 2);

    if_stage_unit u_dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem_addr(imem_addr),
        .imem_data(imem_data), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    if_stage_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .freeze(freeze2), .branch_taken(1'b0),
        .branch_address(32'h0), .imem_addr(imem_addr2),
        .imem_data(32'hDEAD_BEEF), .if_id_pc(if_id_pc2),
        .if_id_instr(if_id_instr2), .if_id_valid(if_id_valid2),
        .stall_count(stall_count2), .flush_count(flush_count2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        valid;
        logic [15:0] stalls;
        logic [15:0] flushes;
    } vec_t;

    vec_t vecs[11];

    initial begin
        //          frz   br    baddr    pc       ifpc     instr    v     stl flu
        vecs[0]  = '{1'b0, 1'b0, 32'h0,  32'h04, 32'h04, 32'h1000, 1'b1, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,  32'h08, 32'h08, 32'h1001, 1'b1, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,  32'h08, 32'h08, 32'h1001, 1'b1, 1, 0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,  32'h08, 32'h08, 32'h1001, 1'b1, 2, 0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,  32'h0C, 32'h0C, 32'h1002, 1'b1, 2, 0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,  32'h10, 32'h10, 32'h1003, 1'b1, 2, 0};
        vecs[6]  = '{1'b0, 1'b1, 32'h43, 32'h40, 32'h00, 32'h0000, 1'b0, 2, 1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  32'h44, 32'h44, 32'h1010, 1'b1, 2, 1};
        vecs[8]  = '{1'b1, 1'b1, 32'h81, 32'h80, 32'h00, 32'h0000, 1'b0, 2, 2};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,  32'h80, 32'h00, 32'h0000, 1'b0, 3, 2};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  32'h84, 32'h84, 32'h1020, 1'b1, 3, 2};

        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
        freeze2 = 1'b1;
        repeat (2) @(posedge clk);

        // Reset asserted mid-cycle must take effect without a clock edge.
        #3 rst = 1'b0;
        #1;
        chk("rst_pc",     {32'h0, imem_addr},   64'h0);
        chk("rst_ifpc",   {32'h0, if_id_pc},    64'h0);
        chk("rst_instr",  {32'h0, if_id_instr}, 64'h0);
        chk("rst_valid",  {63'h0, if_id_valid}, 64'h0);
        chk("rst_stall",  {48'h0, stall_count}, 64'h0);
        chk("rst_flush",  {48'h0, flush_count}, 64'h0);
        chk("rst_pc2",    {32'h0, imem_addr2},  64'hFFFF_FFFC);
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (vecs[i]) begin
            freeze = vecs[i].frz;
            branch_taken = vecs[i].br;
            branch_address = vecs[i].baddr;
            @(posedge clk); #1;
            chk($sformatf("v%0d_pc", i),    {32'h0, imem_addr},   {32'h0, vecs[i].pc});
            chk($sformatf("v%0d_ifpc", i),  {32'h0, if_id_pc},    {32'h0, vecs[i].ifpc});
            chk($sformatf("v%0d_instr", i), {32'h0, if_id_instr}, {32'h0, vecs[i].instr});
            chk($sformatf("v%0d_valid", i), {63'h0, if_id_valid}, {63'h0, vecs[i].valid});
            chk($sformatf("v%0d_stall", i), {48'h0, stall_count}, {48'h0, vecs[i].stalls});
            chk($sformatf("v%0d_flush", i), {48'h0, flush_count}, {48'h0, vecs[i].flushes});
        end

        // Async reset while frozen.
        freeze = 1'b1; branch_taken = 1'b0;
        @(posedge clk); #1;
        #3 rst = 1'b0;
        #1;
        chk("frz_rst_pc",    {32'h0, imem_addr},   64'h0);
        chk("frz_rst_ifpc",  {32'h0, if_id_pc},    64'h0);
        chk("frz_rst_instr", {32'h0, if_id_instr}, 64'h0);
        chk("frz_rst_valid", {63'h0, if_id_valid}, 64'h0);
        chk("frz_rst_stall", {48'h0, stall_count}, 64'h0);
        chk("frz_rst_flush", {48'h0, flush_count}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1; freeze = 1'b0; freeze2 = 1'b0;

        // PC wrap on the second instance, first edge after release.
        @(posedge clk); #1;
        chk("wrap_pc",    {32'h0, imem_addr2},   64'h0);
        chk("wrap_ifpc",  {32'h0, if_id_pc2},    64'h0);
        chk("wrap_instr", {32'h0, if_id_instr2}, 64'hDEAD_BEEF);
        chk("wrap_valid", {63'h0, if_id_valid2}, 64'h1);
        chk("post_rst_pc", {32'h0, imem_addr},   64'h4);

        // Stall counter saturation at 15 with a 4-bit counter.
        freeze2 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sat_%0d", k), {60'h0, stall_count2},
                (k > 15) ? 64'd15 : 64'(k));
        end
        chk("sat_pc_hold", {32'h0, imem_addr2}, 64'h0);
        chk("sat_flush",   {60'h0, flush_count2}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
